// File: rtl/sobel_gradient.sv
// Sobel gradient on 3x3 windows: saturated magnitude, quantised direction,
// and a border flag for windows that straddle the row wrap.
//
// Ports:
//   clk                  clock
//   rstN                 asynchronous active-low reset
//   pixel_data_in[71:0]  3x3 window, byte (R*3+C) = pRC, R=0 top, C=0 left
//   pixel_data_in_valid  window valid this cycle
//   mag_out[7:0]         (|Gx|+|Gy|) >> MAG_SHIFT, saturated to 255
//   dir_out[1:0]         0=0deg 1=45deg 2=90deg 3=135deg
//   border_out           window straddles the row wrap (mag/dir forced 0)
//   out_valid            outputs valid, 3 cycles after the input was presented
module sobel_gradient #(
    parameter int IMAGE_WIDTH = 512,
    parameter int MAG_SHIFT   = 3
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [71:0] pixel_data_in,
    input  logic        pixel_data_in_valid,
    output logic [7:0]  mag_out,
    output logic [1:0]  dir_out,
    output logic        border_out,
    output logic        out_valid
);

    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(IMAGE_WIDTH - 2);

    // a + 2*b + c, max 1020, fits 10 bits without overflow
    function automatic logic [9:0] wsum(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c
    );
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    logic [7:0] w_p00, w_p01, w_p02;
    logic [7:0] w_p10, w_p12;
    logic [7:0] w_p20, w_p21, w_p22;
    logic       w_unused_center;

    assign w_p00 = pixel_data_in[7:0];
    assign w_p01 = pixel_data_in[15:8];
    assign w_p02 = pixel_data_in[23:16];
    assign w_p10 = pixel_data_in[31:24];
    assign w_p12 = pixel_data_in[47:40];
    assign w_p20 = pixel_data_in[55:48];
    assign w_p21 = pixel_data_in[63:56];
    assign w_p22 = pixel_data_in[71:64];
    // the centre pixel carries no weight in either kernel
    assign w_unused_center = ^pixel_data_in[39:32];

    // column position of the incoming window
    logic [COL_W-1:0] r_col;
    logic             w_border;

    assign w_border = (r_col >= COL_EDGE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_col <= '0;
        end else if (pixel_data_in_valid) begin
            r_col <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
        end
    end

    // S1: positive/negative partial sums of each kernel
    logic       r_s1_valid;
    logic       r_s1_border;
    logic [9:0] r_s1_gxp, r_s1_gxn;
    logic [9:0] r_s1_gyp, r_s1_gyn;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1_valid  <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_gxp    <= '0;
            r_s1_gxn    <= '0;
            r_s1_gyp    <= '0;
            r_s1_gyn    <= '0;
        end else begin
            r_s1_valid <= pixel_data_in_valid;
            if (pixel_data_in_valid) begin
                r_s1_border <= w_border;
                r_s1_gxp    <= wsum(w_p02, w_p12, w_p22);
                r_s1_gxn    <= wsum(w_p00, w_p10, w_p20);
                r_s1_gyp    <= wsum(w_p20, w_p21, w_p22);
                r_s1_gyn    <= wsum(w_p00, w_p01, w_p02);
            end
        end
    end

    // S2: signed gradients, -1020..+1020
    logic              r_s2_valid;
    logic              r_s2_border;
    logic signed [10:0] r_s2_gx, r_s2_gy;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s2_valid  <= 1'b0;
            r_s2_border <= 1'b0;
            r_s2_gx     <= '0;
            r_s2_gy     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_border <= r_s1_border;
                r_s2_gx <= $signed({1'b0, r_s1_gxp}) - $signed({1'b0, r_s1_gxn});
                r_s2_gy <= $signed({1'b0, r_s1_gyp}) - $signed({1'b0, r_s1_gyn});
            end
        end
    end

    // magnitude and direction from S2
    logic [9:0]  w_ax, w_ay;
    logic [10:0] w_sum, w_shr;
    logic [7:0]  w_mag;
    logic [12:0] w_2ax, w_5ax, w_2ay, w_5ay;
    logic [1:0]  w_dir;

    assign w_ax  = r_s2_gx[10] ? 10'(-r_s2_gx) : r_s2_gx[9:0];
    assign w_ay  = r_s2_gy[10] ? 10'(-r_s2_gy) : r_s2_gy[9:0];
    assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
    assign w_shr = w_sum >> MAG_SHIFT;
    assign w_mag = (w_shr > 11'd255) ? 8'hFF : w_shr[7:0];

    assign w_2ax = {2'b00, w_ax, 1'b0};
    assign w_5ax = {1'b0, w_ax, 2'b00} + {3'b000, w_ax};
    assign w_2ay = {2'b00, w_ay, 1'b0};
    assign w_5ay = {1'b0, w_ay, 2'b00} + {3'b000, w_ay};

    // tan(22.5) ~ 2/5 and tan(67.5) ~ 5/2; reaching the last two
    // branches implies both gradients are non-zero, so sign bits decide
    always_comb begin
        w_dir = 2'd3;
        if (w_5ay <= w_2ax) begin
            w_dir = 2'd0;
        end else if (w_2ay >= w_5ax) begin
            w_dir = 2'd2;
        end else if (r_s2_gx[10] == r_s2_gy[10]) begin
            w_dir = 2'd1;
        end
    end

    // S3: output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_valid  <= 1'b0;
            mag_out    <= '0;
            dir_out    <= '0;
            border_out <= 1'b0;
        end else begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                border_out <= r_s2_border;
                mag_out    <= r_s2_border ? 8'd0 : w_mag;
                dir_out    <= r_s2_border ? 2'd0 : w_dir;
            end
        end
    end

endmodule
